// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package ifetch_pkg;

   typedef enum logic [1:0] {IDLE, REQ, DROP} ifetch_state_e;

   localparam int          INSTR_W_DEFAULT = 32;
   localparam logic [31:0] FETCH_STRIDE    = 32'd4;
   localparam logic [31:0] PC_ALIGN_MASK   = 32'hFFFF_FFFC;

   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return pc & PC_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/ifetch_skid_fifo.sv
// Two-entry {pc, instr} skid buffer between instruction memory and decode.
// Flush wins over push/pop in the same cycle.
module ifetch_skid_fifo
   import ifetch_pkg::*;
#(
   parameter int          INSTR_W  = INSTR_W_DEFAULT,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic [31:0]        push_pc,
   input  logic [INSTR_W-1:0] push_instr,
   input  logic               pop,
   input  logic               flush,
   output logic [1:0]         count,
   output logic [31:0]        head_pc,
   output logic [INSTR_W-1:0] head_instr
);

   logic [1:0][31:0]        pc_q;
   logic [1:0][INSTR_W-1:0] instr_q;
   logic                    rd_ptr, wr_ptr;
   logic [1:0]              cnt_q;
   logic                    do_push, do_pop;

   assign do_push = push && (cnt_q != 2'd2);
   assign do_pop  = pop  && (cnt_q != 2'd0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q    <= {2{RESET_PC}};
         instr_q <= '0;
         rd_ptr  <= 1'b0;
         wr_ptr  <= 1'b0;
         cnt_q   <= 2'd0;
      end else if (flush) begin
         rd_ptr  <= 1'b0;
         wr_ptr  <= 1'b0;
         cnt_q   <= 2'd0;
      end else begin
         if (do_push) begin
            pc_q[wr_ptr]    <= push_pc;
            instr_q[wr_ptr] <= push_instr;
            wr_ptr          <= ~wr_ptr;
         end
         if (do_pop)
            rd_ptr <= ~rd_ptr;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 2'd1;
            2'b01:   cnt_q <= cnt_q - 2'd1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign count      = cnt_q;
   assign head_pc    = pc_q[rd_ptr];
   assign head_instr = instr_q[rd_ptr];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch PC sequencer for a wait-stated instruction memory, with redirect handling.
// Optional stall counter enabled by defining IFETCH_PERF_CNT_EN.
module imem_fetch_ctrl
   import ifetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          INSTR_W  = INSTR_W_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               f_redirect,
   input  logic [31:0]        f_redirect_pc,
   input  logic               f_ready,
   output logic               f_valid,
   output logic [INSTR_W-1:0] f_instr,
   output logic [31:0]        f_pc,
   output logic               m_read,
   output logic [31:0]        m_addr,
   input  logic [INSTR_W-1:0] m_rdata,
   input  logic               m_waitrequest,
   output logic [31:0]        stall_cnt
);

   ifetch_state_e state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   drop_addr_q, drop_addr_d;
   logic [31:0]   redirect_tgt;
   logic [1:0]    count;
   logic          push, pop, flush, room;

   assign redirect_tgt = align_pc(f_redirect_pc);
   assign room         = (count != 2'd2);

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      drop_addr_d = drop_addr_q;
      m_read      = 1'b0;
      m_addr      = fetch_pc_q;
      push        = 1'b0;
      flush       = 1'b0;
      case (state_q)
         IDLE: begin
            state_d = REQ;
            if (f_redirect)
               fetch_pc_d = redirect_tgt;
         end
         REQ: begin
            m_read = room;
            if (f_redirect) begin
               flush      = 1'b1;
               fetch_pc_d = redirect_tgt;
               // A stalled read must still complete; park its address and discard it later.
               if (room && m_waitrequest) begin
                  state_d     = DROP;
                  drop_addr_d = fetch_pc_q;
               end
            end else if (room && !m_waitrequest) begin
               push       = 1'b1;
               fetch_pc_d = fetch_pc_q + FETCH_STRIDE;
            end
         end
         DROP: begin
            m_read = 1'b1;
            m_addr = drop_addr_q;
            if (f_redirect) begin
               flush      = 1'b1;
               fetch_pc_d = redirect_tgt;
            end
            if (!m_waitrequest)
               state_d = REQ;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         fetch_pc_q  <= RESET_PC;
         drop_addr_q <= RESET_PC;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         drop_addr_q <= drop_addr_d;
      end
   end

   assign f_valid = (count != 2'd0);
   assign pop     = f_valid && f_ready;

   ifetch_skid_fifo #(
      .INSTR_W  (INSTR_W),
      .RESET_PC (RESET_PC)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_pc    (fetch_pc_q),
      .push_instr (m_rdata),
      .pop        (pop),
      .flush      (flush),
      .count      (count),
      .head_pc    (f_pc),
      .head_instr (f_instr)
   );

`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stall_q <= 32'd0;
      else if (m_read && m_waitrequest)
         stall_q <= stall_q + 32'd1;
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: hand sequences with a pc scoreboard plus a redirect vector table.
module tb_imem_fetch_ctrl;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFETCH_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        f_redirect;
   logic [31:0] f_redirect_pc;
   logic        f_ready;
   logic        f_valid;
   logic [31:0] f_instr;
   logic [31:0] f_pc;
   logic        m_read;
   logic [31:0] m_addr;
   logic [31:0] m_rdata;
   logic        m_waitrequest;
   logic [31:0] stall_cnt;

   int checks = 0;
   int errors = 0;
   logic [31:0] sb[$];
   bit          sb_on = 1'b1;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   assign m_rdata = mem_word(m_addr);

   imem_fetch_ctrl #(.RESET_PC(RESET_PC), .INSTR_W(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .f_redirect    (f_redirect),
      .f_redirect_pc (f_redirect_pc),
      .f_ready       (f_ready),
      .f_valid       (f_valid),
      .f_instr       (f_instr),
      .f_pc          (f_pc),
      .m_read        (m_read),
      .m_addr        (m_addr),
      .m_rdata       (m_rdata),
      .m_waitrequest (m_waitrequest),
      .stall_cnt     (stall_cnt)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One clock cycle: drive inputs mid-cycle, then retire any decode pop against the scoreboard.
   task automatic cyc(input logic redir, input logic [31:0] rpc, input logic rdy, input logic wt);
      logic [31:0] e;
      @(negedge clk);
      f_redirect    = redir;
      f_redirect_pc = rpc;
      f_ready       = rdy;
      m_waitrequest = wt;
      #1;
      if (sb_on && f_valid && f_ready && !f_redirect) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_pop", f_pc, 32'hxxxx_xxxx);
         end else begin
            e = sb.pop_front();
            chk("sb_f_pc", f_pc, e);
            chk("sb_f_instr", f_instr, mem_word(e));
         end
      end
   endtask

   typedef struct {
      logic        redir;
      logic [31:0] rpc;
      logic        wt;
      logic        exp_read;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t tbl[11];

   function automatic vec_t mk(input logic r, input logic [31:0] p, input logic w,
                               input logic er, input logic [31:0] ea,
                               input logic ev, input logic [31:0] ep);
      vec_t v;
      v.redir = r; v.rpc = p; v.wt = w;
      v.exp_read = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
      return v;
   endfunction

   initial begin
      // Redirect-with-accept, then stalled redirect through DROP with two retargets.
      tbl[0]  = mk(1'b1, 32'h40,  1'b0, 1'b1, 32'h30,  1'b1, 32'h2C);
      tbl[1]  = mk(1'b0, 32'h0,   1'b0, 1'b1, 32'h40,  1'b0, 32'h0);
      tbl[2]  = mk(1'b0, 32'h0,   1'b0, 1'b1, 32'h44,  1'b1, 32'h40);
      tbl[3]  = mk(1'b0, 32'h0,   1'b1, 1'b1, 32'h48,  1'b1, 32'h44);
      tbl[4]  = mk(1'b1, 32'h80,  1'b1, 1'b1, 32'h48,  1'b0, 32'h0);
      tbl[5]  = mk(1'b1, 32'h200, 1'b1, 1'b1, 32'h48,  1'b0, 32'h0);
      tbl[6]  = mk(1'b1, 32'h103, 1'b1, 1'b1, 32'h48,  1'b0, 32'h0);
      tbl[7]  = mk(1'b0, 32'h0,   1'b0, 1'b1, 32'h48,  1'b0, 32'h0);
      tbl[8]  = mk(1'b0, 32'h0,   1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
      tbl[9]  = mk(1'b0, 32'h0,   1'b0, 1'b1, 32'h104, 1'b1, 32'h100);
      tbl[10] = mk(1'b0, 32'h0,   1'b0, 1'b1, 32'h108, 1'b1, 32'h104);

      rst = 1'b0; f_redirect = 1'b0; f_redirect_pc = 32'h0; f_ready = 1'b1; m_waitrequest = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_f_valid", {31'b0, f_valid}, 32'd0);
      chk("rst_f_instr", f_instr, 32'd0);
      chk("rst_f_pc", f_pc, RESET_PC);
      chk("rst_m_read", {31'b0, m_read}, 32'd0);
      chk("rst_m_addr", m_addr, RESET_PC);
      chk("rst_stall_cnt", stall_cnt, 32'd0);

      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("idle_m_read", {31'b0, m_read}, 32'd0);

      // Zero-wait streaming: one address per cycle, no bubbles.
      for (int k = 0; k < 8; k++) begin
         cyc(1'b0, 32'h0, 1'b1, 1'b0);
         chk("stream_m_read", {31'b0, m_read}, 32'd1);
         chk("stream_m_addr", m_addr, 32'(k * 4));
         if (k >= 1) chk("stream_f_valid", {31'b0, f_valid}, 32'd1);
         sb.push_back(32'(k * 4));
      end

      // Three wait states on 0x20: request held stable.
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 32'h0, 1'b1, 1'b1);
         chk("stall_m_read", {31'b0, m_read}, 32'd1);
         chk("stall_m_addr", m_addr, 32'h20);
      end
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      chk("stall_accept_addr", m_addr, 32'h20);
      sb.push_back(32'h20);
      chk("stall_cnt_3", stall_cnt, PERF ? 32'd3 : 32'd0);

      // Decode back-pressure fills the FIFO and throttles reads.
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      chk("bp_m_addr", m_addr, 32'h24);
      sb.push_back(32'h24);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 32'h0, 1'b0, 1'b0);
         chk("bp_full_m_read", {31'b0, m_read}, 32'd0);
         chk("bp_full_f_pc", f_pc, 32'h20);
      end
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      chk("bp_resume_m_read", {31'b0, m_read}, 32'd0);
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      chk("bp_resume_addr0", m_addr, 32'h28);
      sb.push_back(32'h28);
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      chk("bp_resume_addr1", m_addr, 32'h2C);
      chk("sb_drained_before_table", 32'(sb.size()), 32'd0);

      sb_on = 1'b0;
      sb.delete();
      for (int i = 0; i < 11; i++) begin
         cyc(tbl[i].redir, tbl[i].rpc, 1'b1, tbl[i].wt);
         chk($sformatf("tbl%0d_m_read", i), {31'b0, m_read}, {31'b0, tbl[i].exp_read});
         chk($sformatf("tbl%0d_m_addr", i), m_addr, tbl[i].exp_addr);
         chk($sformatf("tbl%0d_f_valid", i), {31'b0, f_valid}, {31'b0, tbl[i].exp_valid});
         if (tbl[i].exp_valid) begin
            chk($sformatf("tbl%0d_f_pc", i), f_pc, tbl[i].exp_pc);
            chk($sformatf("tbl%0d_f_instr", i), f_instr, mem_word(tbl[i].exp_pc));
         end
      end
      chk("stall_cnt_7", stall_cnt, PERF ? 32'd7 : 32'd0);

      // Wrap at the top of the address space.
      sb_on = 1'b1;
      cyc(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
      chk("wrap_redir_addr", m_addr, 32'h10C);
      sb.delete();
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      chk("wrap_m_addr0", m_addr, 32'hFFFF_FFFC);
      chk("wrap_flushed", {31'b0, f_valid}, 32'd0);
      sb.push_back(32'hFFFF_FFFC);
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      chk("wrap_m_addr1", m_addr, 32'h0);
      sb.push_back(32'h0);
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      chk("wrap_m_addr2", m_addr, 32'h4);
      sb.push_back(32'h4);

      // Reset asserted in the middle of a stalled read.
      cyc(1'b0, 32'h0, 1'b1, 1'b1);
      chk("pre_rst_stall_addr", m_addr, 32'h8);
      chk("sb_drained_wrap", 32'(sb.size()), 32'd0);
      rst = 1'b0;
      #1;
      chk("async_rst_m_read", {31'b0, m_read}, 32'd0);
      chk("async_rst_m_addr", m_addr, RESET_PC);
      chk("async_rst_f_valid", {31'b0, f_valid}, 32'd0);
      chk("async_rst_stall_cnt", stall_cnt, 32'd0);
      @(negedge clk);
      m_waitrequest = 1'b0;
      rst = 1'b1;
      #1;
      chk("rerst_idle_m_read", {31'b0, m_read}, 32'd0);
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      chk("rerst_m_read", {31'b0, m_read}, 32'd1);
      chk("rerst_m_addr", m_addr, RESET_PC);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-fetch sequencer between the pipeline's fetch stage and the wait-stated instruction memory port. It owns the fetch PC, issues one read per instruction, and honours the memory's waitrequest handshake. Returned words are buffered in a 2-entry skid FIFO so decode back-pressure never violates the memory protocol. Branch/jump redirects are applied cleanly even when a read is stalled mid-handshake.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset (bits [1:0] must be 0)
- INSTR_W, 32, instruction/data width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- f_redirect  in  1  one-cycle pulse: flush and restart fetch at f_redirect_pc
- f_redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 00)
- f_ready  in  1  decode accepts head instruction this cycle
- f_valid  out  1  head instruction valid
- f_instr  out  INSTR_W  head instruction word
- f_pc  out  32  address of f_instr
- m_read  out  1  read request to instruction memory
- m_addr  out  32  byte address, always word aligned
- m_rdata  in  INSTR_W  read data, valid in the cycle m_read=1 and m_waitrequest=0
- m_waitrequest  in  1  memory not ready; request must be held
- stall_cnt  out  32  memory stall cycle counter (see Configuration)

## Operation
- States: IDLE, REQ, DROP. Reset → IDLE. IDLE → REQ unconditionally after one cycle.
- REQ: m_read = (fifo count < 2); m_addr = fetch_pc. Accept = m_read & !m_waitrequest. On accept: push {fetch_pc, m_rdata}; fetch_pc += 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- Handshake rule: once m_read is high with m_waitrequest high, m_read and m_addr hold stable until accept. A push only occurs on accept, so count cannot reach 2 while a request is pending.
- Pop: f_valid & f_ready removes the head. Push and pop in the same cycle leave count unchanged.
- f_valid = (count != 0). f_instr and f_pc come from head entry registers.
- Redirect in REQ:
  - FIFO is flushed that cycle and any pop is ignored.
  - fetch_pc := {f_redirect_pc[31:2], 2'b00}.
  - Request pending and not accepted this cycle → DROP.
  - Request accepted in the same cycle → data discarded (no push); stay REQ at the new PC next cycle.
- DROP: m_read = 1, m_addr = old address held. On accept, data is discarded → REQ. No pushes occur in DROP.
- Redirect while in DROP: target is updated (last one wins); stay in DROP.
- Redirect in IDLE: fetch_pc updated, no flush needed.

## Timing
- Reset values:
  - f_valid=0, f_instr=0, f_pc=RESET_PC.
  - m_read=0, m_addr=RESET_PC.
  - count=0, stall_cnt=0, state=IDLE.
- Reset asserted mid-request drops m_read immediately (async) and abandons the request.
- First read: m_read high in the 2nd cycle after reset release.
- Fetch latency: accept in cycle N → f_valid=1 in cycle N+1.
- Throughput: 1 instruction/cycle with zero wait states and f_ready held high.
- Redirect in cycle N → f_valid=0 in N+1.
  - If nothing was pending: m_addr = target in N+1.
  - If a request was pending: m_addr = target in the cycle after the DROP accept.

## Configuration
- IFETCH_PERF_CNT_EN defined: stall_cnt increments (wrapping) every cycle with m_read=1 and m_waitrequest=1, including DROP cycles. It is cleared only by reset.
- Not defined: stall_cnt is tied to 0, no counter flops are generated, and the port remains present.

## Structure
- Package ifetch_pkg holds:
  - the state enum (IDLE, REQ, DROP);
  - the INSTR_W default;
  - FETCH_STRIDE = 4;
  - the PC alignment mask 32'hFFFF_FFFC.
- Sub-module ifetch_skid_fifo: 2-entry {pc, instr} FIFO with push, pop, flush, count and head outputs.
- Top level contains the FSM, fetch_pc register and optional perf counter.

## Test plan
- Reset release, m_waitrequest=0, f_ready=1, memory word = address → m_addr 0,4,8,… on consecutive cycles; f_instr/f_pc match one cycle later; no bubbles.
- m_waitrequest high 3 cycles at addr 0x8 → m_read/m_addr stable all 3 cycles; single push of 0x8; stall_cnt=3 with IFETCH_PERF_CNT_EN, 0 without.
- f_ready low 4 cycles → count reaches 2, m_read drops; on f_ready high, f_pc order 0x0,0x4,0x8 with no loss or duplication.
- Redirect to 0x103 while addr 0x10 stalled 2 more cycles → 0x10 held until accept, data discarded, next m_addr=0x100; first f_pc after redirect = 0x100.
- Redirect to 0x40 in same cycle as an accept → that data never appears; FIFO empty next cycle; m_addr=0x40 next cycle.
- Redirect to 0xFFFF_FFFC, zero wait → f_pc sequence 0xFFFF_FFFC, 0x0; rst asserted mid-stall → m_read low immediately, fetch resumes at RESET_PC.
